// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-command APB requester.
// Commands come in on a valid/ready port. The target completer is decoded from the address,
// the APB SETUP/ACCESS sequence is run, and the result goes out on a valid/ready response port.
// Optional feature macro: APB_MASTER_TIMEOUT_EN bounds the ACCESS phase to TIMEOUT_CYCLES.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | pselx asserted, penable low, one cycle
// ACCESS | penable high, waiting for pready of the selected completer
// RESP   | rsp_valid high, held until rsp_ready
module apb_master_bridge #(
  parameter int NO_OF_SLAVES    = 16,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int SLAVE_ADDR_BITS = 8,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                               pclk,
  input  logic                               presetn,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic                               cmd_write,
  input  logic [ADDRESS_WIDTH-1:0]           cmd_addr,
  input  logic [DATA_WIDTH-1:0]              cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]            cmd_strb,
  input  logic [2:0]                         cmd_prot,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [DATA_WIDTH-1:0]              rsp_rdata,
  output logic                               rsp_slverr,
  output logic                               rsp_timeout,
  output logic [ADDRESS_WIDTH-1:0]           paddr,
  output logic [NO_OF_SLAVES-1:0]            pselx,
  output logic                               penable,
  output logic                               pwrite,
  output logic [2:0]                         pprot,
  output logic [DATA_WIDTH/8-1:0]            pstrb,
  output logic [DATA_WIDTH-1:0]              pwdata,
  input  logic [NO_OF_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NO_OF_SLAVES-1:0]            pready,
  input  logic [NO_OF_SLAVES-1:0]            pslverr
);

  localparam int STRB_W = DATA_WIDTH / 8;
  // A single completer still needs a one-bit index field so the slice is never empty.
  localparam int IDX_W  = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SETUP  = 2'b01,
    S_ACCESS = 2'b10,
    S_RESP   = 2'b11
  } state_t;

  state_t                    state_q;
  logic                      cmd_ready_q;
  logic                      rsp_valid_q;
  logic [DATA_WIDTH-1:0]     rsp_rdata_q;
  logic                      rsp_slverr_q;
  logic [ADDRESS_WIDTH-1:0]  paddr_q;
  logic [NO_OF_SLAVES-1:0]   pselx_q;
  logic                      penable_q;
  logic                      pwrite_q;
  logic [2:0]                pprot_q;
  logic [STRB_W-1:0]         pstrb_q;
  logic [DATA_WIDTH-1:0]     pwdata_q;
  logic [IDX_W-1:0]          sel_q;

  logic [IDX_W-1:0]          dec_idx;
  logic                      dec_err;
  logic                      pready_sel;
  logic                      pslverr_sel;
  logic [DATA_WIDTH-1:0]     prdata_sel;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0]          tmo_cnt_q;
  logic                      rsp_timeout_q;
`endif

  // Address decode: index field selects the completer, anything above it must be zero.
  always_comb begin
    dec_idx = IDX_W'(cmd_addr >> SLAVE_ADDR_BITS);
    dec_err = (32'(dec_idx) >= 32'(NO_OF_SLAVES)) ||
              ((cmd_addr >> (SLAVE_ADDR_BITS + IDX_W)) != '0);
  end

  // Return-path mux; only the latched completer index is ever looked at.
  always_comb begin
    pready_sel  = pready[sel_q];
    pslverr_sel = pslverr[sel_q];
    prdata_sel  = prdata[sel_q*DATA_WIDTH +: DATA_WIDTH];
  end

  // Sequencer FSM; every APB and response output is a register updated here.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q       <= S_IDLE;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      paddr_q       <= '0;
      pselx_q       <= '0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      pprot_q       <= '0;
      pstrb_q       <= '0;
      pwdata_q      <= '0;
      sel_q         <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
`endif
            if (dec_err) begin
              // Unmapped address: answer straight away, the bus never sees it.
              state_q      <= S_RESP;
              rsp_valid_q  <= 1'b1;
              rsp_slverr_q <= 1'b1;
              rsp_rdata_q  <= '0;
            end else begin
              state_q  <= S_SETUP;
              sel_q    <= dec_idx;
              pselx_q  <= NO_OF_SLAVES'(1) << dec_idx;
              paddr_q  <= cmd_addr;
              pwrite_q <= cmd_write;
              pprot_q  <= cmd_prot;
              pwdata_q <= cmd_wdata;
              pstrb_q  <= cmd_write ? cmd_strb : '0;
            end
          end
        end
        S_SETUP: begin
          state_q   <= S_ACCESS;
          penable_q <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
        end
        S_ACCESS: begin
          if (pready_sel) begin
            state_q      <= S_RESP;
            pselx_q      <= '0;
            penable_q    <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_slverr_q <= pslverr_sel;
            // Read data is only meaningful on an error-free read.
            rsp_rdata_q  <= (!pwrite_q && !pslverr_sel) ? prdata_sel : '0;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (tmo_cnt_q == TMO_LAST) begin
            state_q       <= S_RESP;
            pselx_q       <= '0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_slverr_q  <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_rdata_q   <= '0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
`endif
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_slverr = rsp_slverr_q;
  assign paddr      = paddr_q;
  assign pselx      = pselx_q;
  assign penable    = penable_q;
  assign pwrite     = pwrite_q;
  assign pprot      = pprot_q;
  assign pstrb      = pstrb_q;
  assign pwdata     = pwdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge with a transaction-level reference model.
module tb_apb_master_bridge;

  localparam int N   = 16;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int SW  = DW / 8;
  localparam int SAB = 8;
  localparam int TC  = 16;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic            pclk = 1'b0;
  logic            presetn = 1'b1;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic            cmd_write = 1'b0;
  logic [AW-1:0]   cmd_addr = '0;
  logic [DW-1:0]   cmd_wdata = '0;
  logic [SW-1:0]   cmd_strb = '0;
  logic [2:0]      cmd_prot = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_slverr;
  logic            rsp_timeout;
  logic [AW-1:0]   paddr;
  logic [N-1:0]    pselx;
  logic            penable;
  logic            pwrite;
  logic [2:0]      pprot;
  logic [SW-1:0]   pstrb;
  logic [DW-1:0]   pwdata;
  logic [N*DW-1:0] prdata = '0;
  logic [N-1:0]    pready = '0;
  logic [N-1:0]    pslverr = '0;

  always #5 pclk = ~pclk;

  apb_master_bridge #(
    .NO_OF_SLAVES(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
    .SLAVE_ADDR_BITS(SAB), .TIMEOUT_CYCLES(TC)
  ) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pselx(pselx), .penable(penable), .pwrite(pwrite),
    .pprot(pprot), .pstrb(pstrb), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Random activity on every input the DUT should ignore at this point.
  task automatic noise();
    pready  = 16'($urandom);
    pslverr = 16'($urandom);
    for (int i = 0; i < N*DW/32; i++) prdata[i*32 +: 32] = $urandom;
    cmd_valid = 1'($urandom);
    cmd_write = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_wdata = {$urandom, $urandom};
    cmd_strb  = 8'($urandom);
    cmd_prot  = 3'($urandom);
  endtask

  // One transaction. waits<0 means pready never rises. stop_cyc>0 returns mid-transfer.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [63:0] wd,
                         input logic [7:0] st, input logic [2:0] pr, input int waits,
                         input logic err, input logic [63:0] rd, input int rsp_delay,
                         input int stop_cyc);
    int          sel;
    bit          dec;
    bit          tmo;
    int          acc_len;
    int          k;
    logic [15:0] oh;
    logic [63:0] exp_rd;
    logic        exp_err;
    // 16 completers, 256-byte windows: valid addresses are 0x000..0xFFF.
    dec = (addr >= 32'h1000);
    sel = int'(addr / 256) % 16;
    oh  = 16'(1) << sel;
    if (waits < 0 || waits >= TC) begin
      tmo     = TMO_EN;
      acc_len = TMO_EN ? TC : (1 << 30);
    end else begin
      tmo     = 1'b0;
      acc_len = waits + 1;
    end
    exp_err = dec | tmo | err;
    exp_rd  = (dec || tmo || wr || err) ? 64'h0 : rd;

    chk("cmd_ready_idle", {63'h0, cmd_ready}, 64'h1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
    cmd_wdata = wd;   cmd_strb = st;  cmd_prot = pr;
    @(posedge pclk);
    @(negedge pclk);
    cmd_valid = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (dec || cyc == acc_len + 2) begin
        if (dec) chk("dec_latency", {63'h0, rsp_valid}, {63'h0, cyc == 1});
        for (int r = 0; r <= rsp_delay; r++) begin
          chk("rsp_valid",      {63'h0, rsp_valid},   64'h1);
          chk("rsp_rdata",      rsp_rdata,            exp_rd);
          chk("rsp_slverr",     {63'h0, rsp_slverr},  {63'h0, exp_err});
          chk("rsp_timeout",    {63'h0, rsp_timeout}, {63'h0, tmo});
          chk("cmd_ready_resp", {63'h0, cmd_ready},   64'h0);
          chk("pselx_resp",     {48'h0, pselx},       64'h0);
          chk("penable_resp",   {63'h0, penable},     64'h0);
          noise();
          rsp_ready = (r == rsp_delay);
          @(negedge pclk);
        end
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        pready    = '0;
        chk("rsp_valid_done", {63'h0, rsp_valid}, 64'h0);
        chk("cmd_ready_done", {63'h0, cmd_ready}, 64'h1);
        return;
      end
      chk("pselx",          {48'h0, pselx},     {48'h0, oh});
      chk("penable",        {63'h0, penable},   {63'h0, cyc >= 2});
      chk("rsp_valid_busy", {63'h0, rsp_valid}, 64'h0);
      chk("cmd_ready_busy", {63'h0, cmd_ready}, 64'h0);
      chk("paddr",          {32'h0, paddr},     {32'h0, addr});
      chk("pwrite",         {63'h0, pwrite},    {63'h0, wr});
      chk("pstrb",          {56'h0, pstrb},     {56'h0, wr ? st : 8'h00});
      chk("pwdata",         pwdata,             wd);
      chk("pprot",          {61'h0, pprot},     {61'h0, pr});
      noise();
      k = cyc - 2;
      if (cyc == 1) begin
        pready[sel] = 1'b1;
      end else begin
        pready[sel] = (waits >= 0 && k == waits);
        if (k == waits) begin
          pslverr[sel] = err;
          prdata[sel*DW +: DW] = rd;
        end
      end
      if (cyc == stop_cyc) return;
      @(negedge pclk);
    end
    chk("rsp_bound", {63'h0, rsp_valid}, 64'h1);
  endtask

  // Asynchronous reset in the middle of a transfer, then recovery to IDLE.
  task automatic reset_mid();
    presetn = 1'b0;
    #1;
    chk("rst_pselx",      {48'h0, pselx},       64'h0);
    chk("rst_penable",    {63'h0, penable},     64'h0);
    chk("rst_rsp_valid",  {63'h0, rsp_valid},   64'h0);
    chk("rst_cmd_ready",  {63'h0, cmd_ready},   64'h0);
    chk("rst_paddr",      {32'h0, paddr},       64'h0);
    chk("rst_pwdata",     pwdata,               64'h0);
    chk("rst_pstrb",      {56'h0, pstrb},       64'h0);
    chk("rst_pwrite",     {63'h0, pwrite},      64'h0);
    chk("rst_pprot",      {61'h0, pprot},       64'h0);
    chk("rst_rsp_rdata",  rsp_rdata,            64'h0);
    chk("rst_rsp_slverr", {63'h0, rsp_slverr},  64'h0);
    chk("rst_rsp_tmo",    {63'h0, rsp_timeout}, 64'h0);
    cmd_valid = 1'b0;
    pready    = '0;
    pslverr   = '0;
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    chk("rst_rel_ready0", {63'h0, cmd_ready}, 64'h0);
    @(negedge pclk);
    chk("rst_rel_ready1", {63'h0, cmd_ready}, 64'h1);
    chk("rst_rel_rspv",   {63'h0, rsp_valid}, 64'h0);
    chk("rst_rel_pselx",  {48'h0, pselx},     64'h0);
  endtask

  initial begin
    logic [31:0] a;
    #2 presetn = 1'b0;
    #1;
    chk("por_cmd_ready", {63'h0, cmd_ready}, 64'h0);
    chk("por_pselx",     {48'h0, pselx},     64'h0);
    chk("por_penable",   {63'h0, penable},   64'h0);
    chk("por_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    chk("por_paddr",     {32'h0, paddr},     64'h0);
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    chk("por_rel_ready0", {63'h0, cmd_ready}, 64'h0);
    @(negedge pclk);
    chk("por_rel_ready1", {63'h0, cmd_ready}, 64'h1);

    run_txn(1'b1, 32'h304, 64'h1122334455667788, 8'hFF, 3'b010, 0, 1'b0, 64'h5A5A, 0, 0);
    run_txn(1'b0, 32'h510, 64'h0123456789ABCDEF, 8'hA5, 3'b001, 3, 1'b0,
            64'hDEADBEEF00000001, 0, 0);
    run_txn(1'b0, 32'h1000, 64'h0, 8'h0F, 3'b000, 0, 1'b0, 64'h1234, 0, 0);
    run_txn(1'b1, 32'h008, 64'hCAFEF00D, 8'h0F, 3'b100, 1, 1'b1, 64'h0, 0, 0);
    run_txn(1'b0, 32'h7FC, 64'h0, 8'hFF, 3'b011, 2, 1'b0, 64'hFEEDFACE12345678, 5, 0);
    run_txn(1'b0, 32'hF00, 64'h0, 8'h00, 3'b000, 1, 1'b1, 64'hAAAA5555AAAA5555, 1, 0);
    run_txn(1'b1, 32'hFFFF_F000, 64'h1, 8'h01, 3'b111, 0, 1'b0, 64'h0, 2, 0);

    if (TMO_EN) begin
      run_txn(1'b0, 32'h0A0, 64'h0, 8'h00, 3'b000, -1, 1'b0, 64'h99, 1, 0);
    end else begin
      run_txn(1'b0, 32'h0A0, 64'h0, 8'h00, 3'b000, -1, 1'b0, 64'h99, 1, 100);
      reset_mid();
    end

    run_txn(1'b0, 32'h720, 64'h0, 8'h00, 3'b000, -1, 1'b0, 64'h0, 0, 5);
    reset_mid();

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom | (32'h1000 << $urandom_range(0, 19));
      else                           a = $urandom_range(0, 32'hFFF);
      run_txn(1'($urandom), a, {$urandom, $urandom}, 8'($urandom), 3'($urandom),
              int'($urandom_range(0, 5)), ($urandom_range(0, 3) == 0),
              {$urandom, $urandom}, int'($urandom_range(0, 3)), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
